// File: rtl/eth_udp_tx_packer.sv
// rtl/eth_udp_tx_packer.sv - FIFO word to UDP payload byte packer for the transmit path
//
// Drains 32-bit words from a read FIFO that has one cycle of read latency, slices
// each word MSB first, and serves the bytes to the UDP/MAC transmit engine. A
// transfer is split into packets of at most PKT_WORDS words, and packets are
// separated by at least IFG_CYCLES idle cycles.
//
// Ports:
//   rgmii_clk, rstn            clock, asynchronous active-low reset
//   tx_start, tx_word_count    start pulse and transfer size in words
//   tx_busy, tx_done           transfer in progress, one-cycle completion pulse
//   pkt_count                  packets sent in the current or last transfer
//   fifo_rd_en, fifo_rd_data   FIFO read strobe, data valid the following cycle
//   fifo_rd_count              words currently held in the FIFO
//   udp_tx_req, udp_tx_length  packet request and payload length in bytes
//   udp_tx_ack                 engine accepted the request
//   udp_tx_data_req            engine requests one payload byte
//   udp_tx_data                payload byte, valid the cycle after the request

module eth_udp_tx_packer #(
  parameter int PKT_WORDS  = 256,
  parameter int IFG_CYCLES = 64,
  parameter int CNT_W      = 12
) (
  input  logic             rgmii_clk,
  input  logic             rstn,
  input  logic             tx_start,
  input  logic [15:0]      tx_word_count,
  output logic             tx_busy,
  output logic             tx_done,
  output logic [15:0]      pkt_count,
  output logic             fifo_rd_en,
  input  logic [31:0]      fifo_rd_data,
  input  logic [CNT_W-1:0] fifo_rd_count,
  output logic             udp_tx_req,
  output logic [15:0]      udp_tx_length,
  input  logic             udp_tx_ack,
  input  logic             udp_tx_data_req,
  output logic [7:0]       udp_tx_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_PREFETCH,
    S_REQ,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [15:0] PKT_WORDS_W = 16'(PKT_WORDS);
  localparam logic [15:0] GAP_LAST    = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

  state_t      state_q;
  logic [15:0] remaining_q;
  logic [15:0] pkt_words_q;
  logic [15:0] pkt_count_q;
  logic [15:0] words_rd_q;
  logic [15:0] bytes_left_q;
  logic [15:0] gap_cnt_q;
  logic [31:0] cur_word_q;
  logic [31:0] nxt_word_q;
  logic        nxt_valid_q;
  logic        rd_vld_q;
  logic        tx_busy_q;
  logic        tx_done_q;
  logic        fifo_rd_en_q;
  logic        udp_tx_req_q;
  logic [15:0] udp_tx_length_q;
  logic [7:0]  udp_tx_data_q;

  logic [15:0] pkt_words_d;
  logic [15:0] pkt_len_d;
  logic        data_ok_d;
  logic        serve_d;
  logic        word_start_d;
  logic        rd_issue_d;
  logic [7:0]  byte_d;

  always_comb begin
    pkt_words_d  = (remaining_q > PKT_WORDS_W) ? PKT_WORDS_W : remaining_q;
    pkt_len_d    = {pkt_words_d[13:0], 2'b00};
    data_ok_d    = 32'(fifo_rd_count) >= 32'(pkt_words_d);
    serve_d      = (state_q == S_SEND) && udp_tx_data_req && (bytes_left_q != 16'd0);
    // bytes_left is a multiple of four at every word boundary, so its low bits
    // give the byte position inside the current word.
    word_start_d = serve_d && (bytes_left_q[1:0] == 2'b00);
    // Refill the prefetch slot as soon as its word moves into the current-word
    // register; the refill lands within three cycles, before the next word boundary
    // even under back-to-back requests.
    rd_issue_d   = (state_q == S_SEND) && (words_rd_q < pkt_words_q) &&
                   !fifo_rd_en_q && !rd_vld_q && (!nxt_valid_q || word_start_d);
    byte_d       = 8'h00;
    case (bytes_left_q[1:0])
      2'b00: byte_d = nxt_word_q[31:24];
      2'b11: byte_d = cur_word_q[23:16];
      2'b10: byte_d = cur_word_q[15:8];
      2'b01: byte_d = cur_word_q[7:0];
      default: byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      remaining_q     <= 16'd0;
      pkt_words_q     <= 16'd0;
      pkt_count_q     <= 16'd0;
      words_rd_q      <= 16'd0;
      bytes_left_q    <= 16'd0;
      gap_cnt_q       <= 16'd0;
      cur_word_q      <= 32'd0;
      nxt_word_q      <= 32'd0;
      nxt_valid_q     <= 1'b0;
      rd_vld_q        <= 1'b0;
      tx_busy_q       <= 1'b0;
      tx_done_q       <= 1'b0;
      fifo_rd_en_q    <= 1'b0;
      udp_tx_req_q    <= 1'b0;
      udp_tx_length_q <= 16'd0;
      udp_tx_data_q   <= 8'd0;
    end else begin
      fifo_rd_en_q <= 1'b0;
      rd_vld_q     <= fifo_rd_en_q;

      case (state_q)
        S_IDLE: begin
          if (tx_start) begin
            remaining_q <= tx_word_count;
            pkt_count_q <= 16'd0;
            tx_busy_q   <= 1'b1;
            if (tx_word_count == 16'd0) begin
              tx_done_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              state_q <= S_WAIT_DATA;
            end
          end
        end

        S_WAIT_DATA: begin
          // A packet only starts once every word it needs is already buffered.
          if (data_ok_d) begin
            pkt_words_q     <= pkt_words_d;
            udp_tx_length_q <= pkt_len_d;
            bytes_left_q    <= pkt_len_d;
            fifo_rd_en_q    <= 1'b1;
            words_rd_q      <= 16'd1;
            state_q         <= S_PREFETCH;
          end
        end

        S_PREFETCH: begin
          udp_tx_req_q <= 1'b1;
          state_q      <= S_REQ;
        end

        S_REQ: begin
          if (udp_tx_ack) begin
            udp_tx_req_q <= 1'b0;
            state_q      <= S_SEND;
          end
        end

        S_SEND: begin
          if (rd_issue_d) begin
            fifo_rd_en_q <= 1'b1;
            words_rd_q   <= words_rd_q + 16'd1;
          end
          if (serve_d) begin
            bytes_left_q  <= bytes_left_q - 16'd1;
            udp_tx_data_q <= byte_d;
            if (word_start_d) begin
              cur_word_q  <= nxt_word_q;
              nxt_valid_q <= 1'b0;
            end
            if (bytes_left_q == 16'd1) begin
              remaining_q <= remaining_q - pkt_words_q;
              pkt_count_q <= pkt_count_q + 16'd1;
              gap_cnt_q   <= 16'd0;
              if (remaining_q == pkt_words_q) begin
                tx_done_q <= 1'b1;
                state_q   <= S_DONE;
              end else begin
                state_q <= S_GAP;
              end
            end
          end
        end

        S_GAP: begin
          if (gap_cnt_q >= GAP_LAST) begin
            state_q <= S_WAIT_DATA;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end

        S_DONE: begin
          tx_done_q <= 1'b0;
          tx_busy_q <= 1'b0;
          state_q   <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase

      // The FIFO returns data one cycle after the strobe; it always lands in the
      // prefetch slot, which is guaranteed empty whenever a read is in flight.
      if (rd_vld_q) begin
        nxt_word_q  <= fifo_rd_data;
        nxt_valid_q <= 1'b1;
      end
    end
  end

  assign tx_busy       = tx_busy_q;
  assign tx_done       = tx_done_q;
  assign pkt_count     = pkt_count_q;
  assign fifo_rd_en    = fifo_rd_en_q;
  assign udp_tx_req    = udp_tx_req_q;
  assign udp_tx_length = udp_tx_length_q;
  assign udp_tx_data   = udp_tx_data_q;

endmodule
